fpu_fma_issue: RTL and testbench
================================

// Module: fpu_fma_issue
// PURPOSE
//  Initiator-side controller for the multi-cycle FMA unit's start/done protocol. Accepts FMA-class ops from the core
//  (valid/ready), resolves dynamic rounding, drives start, holds operands, waits for done, returns result on a
//  valid/ready response port. Maintains sticky fflags.NX; bounds each operation with a timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max WAIT cycles without fpu_done before aborting the op (>=1)
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-low
//  req_valid    in   1   request valid
//  req_ready    out  1   request accepted when req_valid&&req_ready
//  req_opcode   in   2   00 FMADD, 01 FMSUB, 10 FNMSUB, 11 FNMADD
//  req_rs1/2/3  in   32  binary32 operands (rs1*rs2 +/- rs3)
//  req_rm       in   3   instruction rm; 111 = dynamic
//  req_rd_addr  in   5   destination register tag
//  csr_frm      in   3   fcsr.frm, used when req_rm==111
//  fpu_start    out  1   one-cycle start pulse to FMA unit
//  fpu_rs1/2/3  out  32  operands to FMA unit, stable from start until done
//  fpu_opcode   out  2   opcode to FMA unit, stable likewise
//  fpu_frm      out  3   resolved static rounding mode, stable likewise
//  fpu_rd       in   32  FMA result, valid in cycle fpu_done==1
//  fpu_flag_nx  in   1   inexact flag, sampled only when fpu_done==1
//  fpu_done     in   1   one-cycle completion pulse
//  rsp_valid    out  1   response valid
//  rsp_ready    in   1   response consumed when rsp_valid&&rsp_ready
//  rsp_data     out  32  result
//  rsp_rd_addr  out  5   tag echoed from request
//  rsp_nx       out  1   inexact for this op
//  rsp_illegal  out  1   illegal rounding mode; no FPU op issued
//  rsp_timeout  out  1   FPU did not complete within TIMEOUT_CYCLES
//  fflags_clr   in   1   clear sticky NX
//  fflags_nx    out  1   sticky accumulated NX
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready=1; operand/response regs 0; timeout counter 0.
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE; req_ready = (state==IDLE) only (one op in flight).
//  IDLE: on accept, register opcode/operands/tag; rm_eff = (req_rm==111)?csr_frm:req_rm.
//   rm_eff in {101,110,111} -> go RESP directly: rsp_illegal=1, rsp_data=0, rsp_nx=0; fpu_start never asserted.
//   else -> ISSUE.
//  ISSUE: fpu_start=1 for exactly this one cycle; counter cleared; ->WAIT. fpu_* outputs driven from regs, unchanged
//   through WAIT (FMA unit samples rs3 late, in its adder stage).
//  WAIT: fpu_done=1 -> capture fpu_rd, fpu_flag_nx into response regs, ->RESP.
//   else counter++; counter==TIMEOUT_CYCLES -> rsp_timeout=1, rsp_data=32'h7FC0_0000, rsp_nx=0, ->RESP.
//   fpu_done and timeout in same cycle: done wins.
//  Latency: accept at cycle 0, fpu_start cycle 1, rsp_valid the cycle after fpu_done.
//  RESP: rsp_valid=1; rsp_* held stable until rsp_valid&&rsp_ready, then ->IDLE (req_ready=1 next cycle).
//  fpu_done outside WAIT is ignored (no state/flag change).
//  Sticky NX: set on response handshake with rsp_nx=1 (never for illegal/timeout). fflags_clr clears it;
//   clr and set in same cycle -> set wins (fflags_nx=1).
//  Reset mid-op: immediate return to reset state; in-flight op dropped, no response; FMA unit shares rst.
// STRUCTURE
//  Package fpu_pkg: fma_op_t enum (FMADD..FNMADD), rm constants RM_RNE=000,RM_RTZ,RM_RDN,RM_RUP,RM_RMM=100,RM_DYN=111,
//  CANON_NAN=32'h7FC0_0000, function resolve_rm(rm,frm) and rm_legal(rm). Single module, no sub-module;
//  parent instantiates fpu_fma_issue beside fpu_fma and wires fpu_* ports point-to-point.
// TESTING
//  Basic: FMADD 3F800000*40000000+3F000000, rm=000, fpu_fma attached -> rsp_data=40200000, nx=0, one fpu_start.
//  Dynamic rm: req_rm=111, csr_frm=001 -> fpu_frm=001 held from start to done; csr_frm=101 -> rsp_illegal=1, no start.
//  Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout, then IDLE.
//  Timeout: TIMEOUT_CYCLES=16, fpu model never pulses done -> rsp_timeout=1, rsp_data=7FC00000 after 16 WAIT cycles.
//  Sticky NX: FMADD 3F800000*3DCCCCCD+3F800000 -> rsp_nx=1, fflags_nx=1; fflags_clr same cycle as next NX set -> stays 1.
//  Reset mid-WAIT: rst low 1 cycle -> all outputs reset values, no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and helpers for the FMA issue controller and its neighbours.
// Rounding-mode encodings follow the RISC-V fcsr.frm / instruction rm field.
package fpu_pkg;

  typedef enum logic [1:0] {
    FMADD  = 2'b00,
    FMSUB  = 2'b01,
    FNMSUB = 2'b10,
    FNMADD = 2'b11
  } fma_op_t;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
    return (rm == RM_DYN) ? frm : rm;
  endfunction

  // Only RNE..RMM name a real rounding mode once dynamic rm is resolved.
  function automatic logic rm_legal(input logic [2:0] rm);
    return (rm <= RM_RMM);
  endfunction

endpackage

// File: rtl/fpu_fma_issue.sv
// Issue/return controller for the multi-cycle FMA unit: one op in flight, start/done
// handshake toward the unit, valid/ready on both core-facing ports, sticky inexact flag.
//
// state   | meaning
// IDLE    | ready for a request (req_ready=1)
// ISSUE   | single-cycle fpu_start pulse, wait counter cleared
// WAIT    | operands held, waiting for fpu_done or timeout
// RESP    | response held on rsp_* until rsp_ready
module fpu_fma_issue
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_opcode,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_rs3,
  input  logic [2:0]  req_rm,
  input  logic [4:0]  req_rd_addr,
  input  logic [2:0]  csr_frm,
  output logic        fpu_start,
  output logic [31:0] fpu_rs1,
  output logic [31:0] fpu_rs2,
  output logic [31:0] fpu_rs3,
  output logic [1:0]  fpu_opcode,
  output logic [2:0]  fpu_frm,
  input  logic [31:0] fpu_rd,
  input  logic        fpu_flag_nx,
  input  logic        fpu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd_addr,
  output logic        rsp_nx,
  output logic        rsp_illegal,
  output logic        rsp_timeout,
  input  logic        fflags_clr,
  output logic        fflags_nx
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } state_t;

  state_t        state, state_nxt;
  fma_op_t       op_q;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_inc;
  logic          accept;
  logic          rsp_hs;
  logic          timeout_hit;
  logic [2:0]    rm_eff;
  logic          rm_ok;

  assign rm_eff       = resolve_rm(req_rm, csr_frm);
  assign rm_ok        = rm_legal(rm_eff);
  assign accept       = req_valid && (state == S_IDLE);
  assign rsp_hs       = rsp_ready && (state == S_RESP);
  assign wait_cnt_inc = wait_cnt + 1'b1;
  assign timeout_hit  = (wait_cnt_inc == CW'(TIMEOUT_CYCLES));

  assign req_ready  = (state == S_IDLE);
  assign rsp_valid  = (state == S_RESP);
  assign fpu_opcode = op_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fpu_start = 1'b0;
    case (state)
      S_IDLE:  if (accept) state_nxt = rm_ok ? S_ISSUE : S_RESP;
      S_ISSUE: begin
        fpu_start = 1'b1;
        state_nxt = S_WAIT;
      end
      // done has priority over a timeout landing in the same cycle
      S_WAIT:  if (fpu_done || timeout_hit) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q        <= FMADD;
      fpu_rs1     <= '0;
      fpu_rs2     <= '0;
      fpu_rs3     <= '0;
      fpu_frm     <= '0;
      rsp_rd_addr <= '0;
      rsp_data    <= '0;
      rsp_nx      <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          rsp_rd_addr <= req_rd_addr;
          rsp_data    <= '0;
          rsp_nx      <= 1'b0;
          rsp_timeout <= 1'b0;
          rsp_illegal <= !rm_ok;
          // illegal ops never reach the unit, so its operand bus stays untouched
          if (rm_ok) begin
            op_q    <= fma_op_t'(req_opcode);
            fpu_rs1 <= req_rs1;
            fpu_rs2 <= req_rs2;
            fpu_rs3 <= req_rs3;
            fpu_frm <= rm_eff;
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          if (fpu_done) begin
            rsp_data <= fpu_rd;
            rsp_nx   <= fpu_flag_nx;
          end else begin
            wait_cnt <= wait_cnt_inc;
            if (timeout_hit) begin
              rsp_timeout <= 1'b1;
              rsp_data    <= CANON_NAN;
              rsp_nx      <= 1'b0;
            end
          end
        end
        S_RESP: if (rsp_ready) begin
          rsp_data    <= '0;
          rsp_nx      <= 1'b0;
          rsp_illegal <= 1'b0;
          rsp_timeout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // A set on the same cycle as a clear must win so no inexact event is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  fflags_nx <= 1'b0;
    else if (rsp_hs && rsp_nx) fflags_nx <= 1'b1;
    else if (fflags_clr)       fflags_nx <= 1'b0;
  end

endmodule

// File: tb/tb_fpu_fma_issue.sv
// Self-checking bench for fpu_fma_issue: directed vector table, hand-written corner
// sequences and randomized ops against a behavioural FMA-unit model.
module tb_fpu_fma_issue;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_opcode = '0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
  logic [2:0]  req_rm = '0;
  logic [4:0]  req_rd_addr = '0;
  logic [2:0]  csr_frm = '0;
  logic        fpu_start;
  logic [31:0] fpu_rs1, fpu_rs2, fpu_rs3;
  logic [1:0]  fpu_opcode;
  logic [2:0]  fpu_frm;
  logic [31:0] fpu_rd = '0;
  logic        fpu_flag_nx = 1'b0;
  logic        fpu_done = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd_addr;
  logic        rsp_nx, rsp_illegal, rsp_timeout;
  logic        fflags_clr = 1'b0;
  logic        fflags_nx;

  fpu_fma_issue #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
    .req_rm(req_rm), .req_rd_addr(req_rd_addr), .csr_frm(csr_frm),
    .fpu_start(fpu_start), .fpu_rs1(fpu_rs1), .fpu_rs2(fpu_rs2), .fpu_rs3(fpu_rs3),
    .fpu_opcode(fpu_opcode), .fpu_frm(fpu_frm),
    .fpu_rd(fpu_rd), .fpu_flag_nx(fpu_flag_nx), .fpu_done(fpu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd_addr(rsp_rd_addr), .rsp_nx(rsp_nx), .rsp_illegal(rsp_illegal),
    .rsp_timeout(rsp_timeout), .fflags_clr(fflags_clr), .fflags_nx(fflags_nx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // binary32 <-> double for normal values and zero; FMA computed exactly-ish in double then rounded RNE
  function automatic real s2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) d = {x[31], 63'd0};
    else d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  task automatic r2s(input real r, output logic [31:0] s, output logic nx);
    logic [63:0] d;
    logic [28:0] rem;
    logic [30:0] mag;
    d = $realtobits(r);
    if (r == 0.0) begin
      s  = {d[63], 31'd0};
      nx = 1'b0;
    end else begin
      mag = {8'(d[62:52] - 11'd896), d[51:29]};
      rem = d[28:0];
      nx  = (rem != 29'd0);
      if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && mag[0])) mag = mag + 31'd1;
      s = {d[63], mag};
    end
  endtask

  task automatic fma_ref(input logic [1:0] op, input logic [31:0] a, b, c,
                         output logic [31:0] res, output logic nx);
    real p, s;
    p = s2r(a) * s2r(b);
    case (op)
      2'b00:   s = p + s2r(c);
      2'b01:   s = p - s2r(c);
      2'b10:   s = -p + s2r(c);
      default: s = -p - s2r(c);
    endcase
    r2s(s, res, nx);
  endtask

  // FMA unit model: done after fpu_lat cycles (0 = never), result computed from the
  // operand bus at done time, so late-sampled operands must still be held.
  int          fpu_lat = 1;
  int          start_cnt = 0;
  logic [2:0]  start_frm = '0;
  bit          stab_err = 0;
  bit          inject_stray = 0;

  initial begin
    bit busy;
    int remaining;
    logic [31:0] s1, s2, s3, r;
    logic [1:0] sop;
    logic [2:0] sfrm;
    logic nx;
    busy = 0;
    remaining = 0;
    forever begin
      @(posedge clk);
      #1;
      fpu_done    = 1'b0;
      fpu_flag_nx = 1'b0;
      fpu_rd      = $urandom;
      if (fpu_start) start_cnt++;
      if (!rst) busy = 0;
      else if (busy) begin
        if (fpu_rs1 != s1 || fpu_rs2 != s2 || fpu_rs3 != s3 || fpu_opcode != sop || fpu_frm != sfrm)
          stab_err = 1;
        remaining--;
        if (remaining == 0) begin
          busy = 0;
          fma_ref(fpu_opcode, fpu_rs1, fpu_rs2, fpu_rs3, r, nx);
          fpu_rd      = r;
          fpu_flag_nx = nx;
          fpu_done    = 1'b1;
        end
      end else if (fpu_start) begin
        start_frm = fpu_frm;
        s1 = fpu_rs1; s2 = fpu_rs2; s3 = fpu_rs3; sop = fpu_opcode; sfrm = fpu_frm;
        if (fpu_lat > 0) begin
          busy = 1;
          remaining = fpu_lat;
        end
      end
      if (inject_stray) begin
        fpu_done     = 1'b1;
        fpu_flag_nx  = 1'b1;
        fpu_rd       = 32'hDEAD_BEEF;
        inject_stray = 0;
      end
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        nx, ill, to;
    logic [4:0]  tag;
    int          n;
    int          starts;
    logic [2:0]  frm;
    bit          stab_err;
    bit          hold_ok;
    logic        ready_after;
    logic        valid_after;
  } obs_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, b, c,
                       input logic [2:0] rm, frm, input logic [4:0] tag,
                       input int lat, input int hold, input bit clr_hs, output obs_t o);
    int guard;
    int s0;
    o = '{default: 0};
    fpu_lat  = lat;
    stab_err = 0;
    s0       = start_cnt;
    req_opcode = op; req_rs1 = a; req_rs2 = b; req_rs3 = c;
    req_rm = rm; csr_frm = frm; req_rd_addr = tag;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 200) begin step(); guard++; end
    step();
    req_valid = 1'b0;
    req_rs1 = $urandom; req_rs2 = $urandom; req_rs3 = $urandom;
    csr_frm = 3'($urandom);
    o.n = 1;
    while (!rsp_valid && o.n < 100) begin step(); o.n++; end
    o.data = rsp_data; o.nx = rsp_nx; o.ill = rsp_illegal; o.to = rsp_timeout;
    o.tag = rsp_rd_addr;
    o.hold_ok = 1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!rsp_valid || req_ready || rsp_data != o.data || rsp_nx != o.nx ||
          rsp_illegal != o.ill || rsp_timeout != o.to || rsp_rd_addr != o.tag)
        o.hold_ok = 0;
    end
    rsp_ready  = 1'b1;
    fflags_clr = clr_hs;
    step();
    rsp_ready  = 1'b0;
    fflags_clr = 1'b0;
    o.ready_after = req_ready;
    o.valid_after = rsp_valid;
    o.starts   = start_cnt - s0;
    o.frm      = start_frm;
    o.stab_err = stab_err;
  endtask

  task automatic verify(input string nm, input obs_t o, input logic [31:0] edata,
                        input logic enx, eill, eto, input logic [4:0] etag,
                        input int en, input logic [2:0] efrm);
    check({nm, "_data"}, o.data, edata);
    check({nm, "_nx"}, o.nx, enx);
    check({nm, "_illegal"}, o.ill, eill);
    check({nm, "_timeout"}, o.to, eto);
    check({nm, "_tag"}, o.tag, etag);
    check({nm, "_latency"}, o.n, en);
    check({nm, "_starts"}, o.starts, eill ? 0 : 1);
    if (!eill) begin
      check({nm, "_frm"}, o.frm, efrm);
      check({nm, "_stable"}, o.stab_err, 0);
    end
    check({nm, "_hold"}, o.hold_ok, 1);
    check({nm, "_idle_after"}, {o.ready_after, o.valid_after}, 2'b10);
  endtask

  task automatic pulse_clr();
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, c;
    logic [2:0]  rm, frm;
    int          lat;
    logic [31:0] edata;
    bit          enx, eill;
    logic [2:0]  efrm;
  } vec_t;

  vec_t vt[10];

  initial begin
    obs_t o;
    logic [31:0] ed;
    logic enx, eill, eto;
    logic [2:0] rme;
    int en, seen, lat, hold;
    logic sticky;
    logic [1:0] rop;
    logic [31:0] ra, rb, rc;
    logic [2:0] rrm, rfrm;

    vt[0] = '{2'b00, 32'h3F800000, 32'h40000000, 32'h3F000000, 3'b000, 3'b000, 1, 32'h40200000, 0, 0, 3'b000};
    vt[1] = '{2'b00, 32'h3F800000, 32'h3DCCCCCD, 32'h3F800000, 3'b000, 3'b010, 3, 32'h3F8CCCCD, 1, 0, 3'b000};
    vt[2] = '{2'b01, 32'h40000000, 32'h40000000, 32'h3F800000, 3'b111, 3'b001, 2, 32'h40400000, 0, 0, 3'b001};
    vt[3] = '{2'b00, 32'h3F800000, 32'h40000000, 32'h3F000000, 3'b111, 3'b101, 1, 32'h0, 0, 1, 3'b000};
    vt[4] = '{2'b00, 32'h3F800000, 32'h40000000, 32'h3F000000, 3'b101, 3'b000, 1, 32'h0, 0, 1, 3'b000};
    vt[5] = '{2'b00, 32'h3F800000, 32'h40000000, 32'h3F000000, 3'b110, 3'b000, 1, 32'h0, 0, 1, 3'b000};
    vt[6] = '{2'b00, 32'h3F800000, 32'h40000000, 32'h3F000000, 3'b111, 3'b111, 1, 32'h0, 0, 1, 3'b000};
    vt[7] = '{2'b10, 32'h40000000, 32'h40000000, 32'h3F800000, 3'b100, 3'b110, 4, 32'hC0400000, 0, 0, 3'b100};
    vt[8] = '{2'b11, 32'h3F800000, 32'h40000000, 32'h3F000000, 3'b011, 3'b000, 5, 32'hC0200000, 0, 0, 3'b011};
    vt[9] = '{2'b00, 32'h40000000, 32'h3F000000, 32'h00000000, 3'b111, 3'b100, 7, 32'h3F800000, 0, 0, 3'b100};

    // reset state
    repeat (3) step();
    check("reset_ports", {req_ready, rsp_valid, fpu_start, fflags_nx, rsp_nx, rsp_illegal, rsp_timeout},
          7'b1000000);
    check("reset_data", {fpu_rs1, rsp_data}, 64'd0);
    check("reset_fpu_misc", {fpu_rs2, fpu_rs3[31:8], fpu_opcode, fpu_frm, rsp_rd_addr}, 64'd0);
    rst = 1'b1;
    step();

    // directed table, with a 5-cycle backpressure on the first op
    for (int i = 0; i < 10; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].c, vt[i].rm, vt[i].frm, 5'(i + 3),
            vt[i].lat, (i == 0) ? 5 : 0, 0, o);
      verify($sformatf("vec%0d", i), o, vt[i].edata, vt[i].enx, vt[i].eill, 1'b0, 5'(i + 3),
             vt[i].eill ? 1 : vt[i].lat + 2, vt[i].efrm);
    end
    check("sticky_after_table", fflags_nx, 1'b1);
    pulse_clr();
    check("sticky_cleared", fflags_nx, 1'b0);

    // timeout: unit never completes
    do_op(2'b00, 32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 3'b000, 5'd20, 0, 2, 0, o);
    verify("timeout", o, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 5'd20, TO + 2, 3'b000);
    // done on the last WAIT cycle beats the timeout
    do_op(2'b00, 32'h3F800000, 32'h3DCCCCCD, 32'h3F800000, 3'b010, 3'b000, 5'd21, TO, 0, 0, o);
    verify("done_at_limit", o, 32'h3F8CCCCD, 1'b1, 1'b0, 1'b0, 5'd21, TO + 2, 3'b010);
    pulse_clr();

    // illegal and timeout responses never set sticky NX
    do_op(2'b00, 32'h3F800000, 32'h3DCCCCCD, 32'h3F800000, 3'b110, 3'b000, 5'd22, 1, 0, 0, o);
    check("sticky_not_illegal", fflags_nx, 1'b0);

    // clear and set in the same cycle: set wins
    do_op(2'b00, 32'h3F800000, 32'h3DCCCCCD, 32'h3F800000, 3'b000, 3'b000, 5'd23, 2, 1, 1, o);
    check("sticky_set_beats_clr", fflags_nx, 1'b1);
    pulse_clr();

    // stray done while idle is ignored
    inject_stray = 1;
    repeat (3) step();
    check("stray_done_ignored", {req_ready, rsp_valid, fflags_nx}, 3'b100);

    // reset in the middle of WAIT
    fpu_lat = 0;
    req_opcode = 2'b01; req_rs1 = 32'h40000000; req_rs2 = 32'h40400000; req_rs3 = 32'h3F800000;
    req_rm = 3'b001; req_rd_addr = 5'd9; req_valid = 1'b1;
    en = start_cnt;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    check("midwait_started", start_cnt - en, 1);
    rst = 1'b0;
    #1;
    check("midwait_reset_ports", {req_ready, rsp_valid, fpu_start, rsp_illegal, rsp_timeout, fflags_nx},
          6'b100000);
    check("midwait_reset_regs", {fpu_rs1, fpu_frm, fpu_opcode, rsp_rd_addr}, 64'd0);
    step();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    check("midwait_no_response", seen, 0);
    do_op(2'b00, 32'h3F800000, 32'h40000000, 32'h3F000000, 3'b000, 3'b000, 5'd11, 2, 0, 0, o);
    verify("after_reset", o, 32'h40200000, 1'b0, 1'b0, 1'b0, 5'd11, 4, 3'b000);

    // randomized ops against the reference model
    pulse_clr();
    sticky = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rop  = 2'($urandom);
      ra   = {1'($urandom), 8'($urandom_range(115, 140)), 23'($urandom)};
      rb   = {1'($urandom), 8'($urandom_range(115, 140)), 23'($urandom)};
      rc   = {1'($urandom), 8'($urandom_range(115, 140)), 23'($urandom)};
      rrm  = 3'($urandom);
      rfrm = 3'($urandom);
      lat  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      hold = $urandom_range(0, 3);
      rme  = (rrm == 3'b111) ? rfrm : rrm;
      eill = (rme > 3'b100);
      eto  = 1'b0;
      if (eill) begin
        ed = 32'd0; enx = 1'b0; en = 1;
      end else if (lat == 0) begin
        ed = 32'h7FC00000; enx = 1'b0; eto = 1'b1; en = TO + 2;
      end else begin
        fma_ref(rop, ra, rb, rc, ed, enx);
        en = lat + 2;
      end
      do_op(rop, ra, rb, rc, rrm, rfrm, 5'(i), lat, hold, 0, o);
      verify($sformatf("rnd%0d", i), o, ed, enx, eill, eto, 5'(i), en, rme);
      sticky = sticky | enx;
      check($sformatf("rnd%0d_sticky", i), fflags_nx, sticky);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
